// File: rtl/mandel_ctrl_pkg.sv
// Shared constants, request-state type and sizing helper for the Mandelbrot
// control blocks.
package mandel_ctrl_pkg;

    localparam int HOLD_PULSE = 0;
    localparam int HOLD_ACK   = 1;

    typedef enum logic {IDLE, REQ} req_state_t;

    // Bits needed to count 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_update_ctrl_if.sv
// Switch-conditioning bus: raw pins and power-up/ack in, debounced levels and
// the coalesced update request out.
interface sw_update_ctrl_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0] sw_async;
    logic            pwrup_en;
    logic            update_ack;
    logic [N_SW-1:0] resolution;
    logic            update;
    logic [N_SW-1:0] sw_changed;
    logic            pwrup_done;

    modport master (
        output sw_async, pwrup_en, update_ack,
        input  resolution, update, sw_changed, pwrup_done
    );

    modport slave (
        input  sw_async, pwrup_en, update_ack,
        output resolution, update, sw_changed, pwrup_done
    );
endinterface

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser chain followed by a saturating-free
// debounce counter that accepts a new level after DEBOUNCE_CYCLES stable cycles.
module sw_debounce_ch
    import mandel_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic SYS_RESETn,
    input  logic sw_async_i,
    output logic level_o,
    output logic chg_o
);
    localparam int              CNT_W   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   chg;

    assign sync = sync_q[SYNC_STAGES-1];

    // Counter is cleared on acceptance, so it never reaches past CNT_MAX.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        chg     = 1'b0;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync;
            cnt_d   = '0;
            chg     = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!SYS_RESETn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_async_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign chg_o   = chg;

endmodule

// File: rtl/sw_update_ctrl.sv
// Debounces N_SW switches and coalesces power-up and switch-change events into
// a single update request, either pulsed or held until acknowledged.
module sw_update_ctrl
    import mandel_ctrl_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int PWRUP_DELAY     = 16,
    parameter int HOLD_MODE       = HOLD_PULSE
) (
    input  logic            clk,
    input  logic            SYS_RESETn,
    sw_update_ctrl_if.slave bus
);
    localparam int               PU_W   = (clog2(PWRUP_DELAY) < 1) ? 1 : clog2(PWRUP_DELAY);
    localparam logic [PU_W-1:0]  PU_MAX = PU_W'(PWRUP_DELAY - 1);

    logic [N_SW-1:0] level;
    logic [N_SW-1:0] chg;

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .SYS_RESETn(SYS_RESETn),
            .sw_async_i(bus.sw_async[g]),
            .level_o   (level[g]),
            .chg_o     (chg[g])
        );
    end

    logic [PU_W-1:0] pu_cnt_q, pu_cnt_d;
    logic            pwrup_done_q, pwrup_done_d;
    logic            pu_evt;
    req_state_t      state_q, state_d;
    logic            update_q, update_d;
    logic [N_SW-1:0] mask_q, mask_d;
    logic            evt;

    assign pu_evt = bus.pwrup_en && !pwrup_done_q && (pu_cnt_q == PU_MAX);
    assign evt    = (|chg) || pu_evt;

    // Counter holds at its terminal value once done so it cannot wrap.
    always_comb begin
        pu_cnt_d     = pu_cnt_q;
        pwrup_done_d = pwrup_done_q || pu_evt;
        if (!bus.pwrup_en)    pu_cnt_d = '0;
        else if (!pwrup_done_q && !pu_evt) pu_cnt_d = pu_cnt_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        update_d = 1'b0;
        mask_d   = mask_q;
        if (HOLD_MODE == HOLD_ACK) begin
            case (state_q)
                IDLE: begin
                    if (evt) begin
                        state_d  = REQ;
                        update_d = 1'b1;
                        mask_d   = chg;
                    end
                end
                REQ: begin
                    update_d = 1'b1;
                    // A fresh event beats a same-cycle ack: the consumer has
                    // not seen these bits yet, so the request restarts with them.
                    if (evt) begin
                        mask_d = bus.update_ack ? chg : (mask_q | chg);
                    end else if (bus.update_ack) begin
                        state_d  = IDLE;
                        update_d = 1'b0;
                        mask_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (evt) begin
            update_d = 1'b1;
            mask_d   = chg;
        end
    end

    always_ff @(posedge clk) begin
        if (!SYS_RESETn) begin
            pu_cnt_q     <= '0;
            pwrup_done_q <= 1'b0;
            state_q      <= IDLE;
            update_q     <= 1'b0;
            mask_q       <= '0;
        end else begin
            pu_cnt_q     <= pu_cnt_d;
            pwrup_done_q <= pwrup_done_d;
            state_q      <= state_d;
            update_q     <= update_d;
            mask_q       <= mask_d;
        end
    end

    assign bus.resolution = level;
    assign bus.update     = update_q;
    assign bus.sw_changed = mask_q;
    assign bus.pwrup_done = pwrup_done_q;

endmodule

// File: tb/tb_sw_update_ctrl.sv
// Directed bench: a pulse-mode and a hold-mode instance share clock and reset;
// each scenario task drives pins and checks hand-computed outputs.
module tb_sw_update_ctrl;
    import mandel_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    sw_update_ctrl_if #(.N_SW(4)) if0 ();
    sw_update_ctrl_if #(.N_SW(4)) if1 ();

    sw_update_ctrl #(
        .N_SW(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PWRUP_DELAY(16), .HOLD_MODE(HOLD_PULSE)
    ) dut0 (
        .clk(clk), .SYS_RESETn(rst_n), .bus(if0)
    );

    sw_update_ctrl #(
        .N_SW(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PWRUP_DELAY(16), .HOLD_MODE(HOLD_ACK)
    ) dut1 (
        .clk(clk), .SYS_RESETn(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs set afterwards are sampled at the next edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.sw_async = 4'b0000; if0.pwrup_en = 1'b0; if0.update_ack = 1'b0;
        if1.sw_async = 4'b0000; if1.pwrup_en = 1'b0; if1.update_ack = 1'b0;
        tick(3);
        vectors++;
        if ({if0.resolution, if0.update, if0.sw_changed, if0.pwrup_done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_m0: got %b expected 0", {if0.resolution, if0.update, if0.sw_changed, if0.pwrup_done});
        end
        vectors++;
        if ({if1.resolution, if1.update, if1.sw_changed, if1.pwrup_done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_m1: got %b expected 0", {if1.resolution, if1.update, if1.sw_changed, if1.pwrup_done});
        end
    endtask

    task automatic test_pwrup();
        rst_n = 1'b1;
        if0.pwrup_en = 1'b1;
        tick(15);
        vectors++;
        if (if0.update !== 1'b0 || if0.pwrup_done !== 1'b0) begin
            errors++;
            $display("FAIL pwrup_early: got upd=%b done=%b expected 0 0", if0.update, if0.pwrup_done);
        end
        tick(1);
        vectors++;
        if (if0.update !== 1'b1 || if0.pwrup_done !== 1'b1 || if0.sw_changed !== 4'b0000) begin
            errors++;
            $display("FAIL pwrup_edge16: got upd=%b done=%b mask=%b expected 1 1 0000",
                     if0.update, if0.pwrup_done, if0.sw_changed);
        end
        tick(1);
        vectors++;
        if (if0.update !== 1'b0 || if0.pwrup_done !== 1'b1) begin
            errors++;
            $display("FAIL pwrup_pulse: got upd=%b done=%b expected 0 1", if0.update, if0.pwrup_done);
        end
    endtask

    task automatic test_settle();
        if0.sw_async = 4'b0101;
        tick(9);
        vectors++;
        if (if0.resolution !== 4'b0000 || if0.update !== 1'b0) begin
            errors++;
            $display("FAIL settle_edge9: got res=%b upd=%b expected 0000 0", if0.resolution, if0.update);
        end
        tick(1);
        vectors++;
        if (if0.resolution !== 4'b0101 || if0.update !== 1'b1 || if0.sw_changed !== 4'b0101) begin
            errors++;
            $display("FAIL settle_edge10: got res=%b upd=%b mask=%b expected 0101 1 0101",
                     if0.resolution, if0.update, if0.sw_changed);
        end
        tick(1);
        vectors++;
        if (if0.update !== 1'b0 || if0.sw_changed !== 4'b0101) begin
            errors++;
            $display("FAIL settle_hold: got upd=%b mask=%b expected 0 0101", if0.update, if0.sw_changed);
        end
    endtask

    task automatic test_bounce();
        if0.sw_async = 4'b0001;
        tick(10);
        vectors++;
        if (if0.resolution !== 4'b0001 || if0.update !== 1'b1 || if0.sw_changed !== 4'b0100) begin
            errors++;
            $display("FAIL bounce_pre: got res=%b upd=%b mask=%b expected 0001 1 0100",
                     if0.resolution, if0.update, if0.sw_changed);
        end
        for (int seg = 0; seg < 8; seg++) begin
            if0.sw_async[2] = (seg % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                tick(1);
                vectors++;
                if (if0.update !== 1'b0 || if0.resolution !== 4'b0001) begin
                    errors++;
                    $display("FAIL bounce_quiet: seg=%0d got upd=%b res=%b expected 0 0001",
                             seg, if0.update, if0.resolution);
                end
            end
        end
        if0.sw_async[2] = 1'b1;
        tick(9);
        vectors++;
        if (if0.update !== 1'b0) begin
            errors++;
            $display("FAIL bounce_edge9: got upd=%b expected 0", if0.update);
        end
        tick(1);
        vectors++;
        if (if0.resolution !== 4'b0101 || if0.update !== 1'b1 || if0.sw_changed !== 4'b0100) begin
            errors++;
            $display("FAIL bounce_final: got res=%b upd=%b mask=%b expected 0101 1 0100",
                     if0.resolution, if0.update, if0.sw_changed);
        end
    endtask

    task automatic test_hold_accum();
        if1.sw_async = 4'b0001;
        tick(10);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0001) begin
            errors++;
            $display("FAIL hold_first: got upd=%b mask=%b expected 1 0001", if1.update, if1.sw_changed);
        end
        if1.sw_async = 4'b1001;
        tick(5);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0001) begin
            errors++;
            $display("FAIL hold_wait: got upd=%b mask=%b expected 1 0001", if1.update, if1.sw_changed);
        end
        tick(5);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b1001 || if1.resolution !== 4'b1001) begin
            errors++;
            $display("FAIL hold_or: got upd=%b mask=%b res=%b expected 1 1001 1001",
                     if1.update, if1.sw_changed, if1.resolution);
        end
        if1.update_ack = 1'b1;
        tick(1);
        if1.update_ack = 1'b0;
        vectors++;
        if (if1.update !== 1'b0 || if1.sw_changed !== 4'b0000) begin
            errors++;
            $display("FAIL hold_ack: got upd=%b mask=%b expected 0 0000", if1.update, if1.sw_changed);
        end
        if1.update_ack = 1'b1;
        tick(1);
        if1.update_ack = 1'b0;
        vectors++;
        if (if1.update !== 1'b0 || if1.sw_changed !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ack: got upd=%b mask=%b expected 0 0000", if1.update, if1.sw_changed);
        end
    endtask

    task automatic test_ack_collision();
        if1.sw_async = 4'b0001;
        tick(3);
        if1.sw_async = 4'b0011;
        tick(7);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b1000) begin
            errors++;
            $display("FAIL coll_first: got upd=%b mask=%b expected 1 1000", if1.update, if1.sw_changed);
        end
        tick(2);
        if1.update_ack = 1'b1;
        tick(1);
        if1.update_ack = 1'b0;
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0010 || if1.resolution !== 4'b0011) begin
            errors++;
            $display("FAIL coll_evt_wins: got upd=%b mask=%b res=%b expected 1 0010 0011",
                     if1.update, if1.sw_changed, if1.resolution);
        end
        tick(1);
        vectors++;
        if (if1.update !== 1'b1) begin
            errors++;
            $display("FAIL coll_held: got upd=%b expected 1", if1.update);
        end
        if1.update_ack = 1'b1;
        tick(1);
        if1.update_ack = 1'b0;
        vectors++;
        if (if1.update !== 1'b0 || if1.sw_changed !== 4'b0000) begin
            errors++;
            $display("FAIL coll_release: got upd=%b mask=%b expected 0 0000", if1.update, if1.sw_changed);
        end
    endtask

    task automatic test_reset_midflight();
        if1.sw_async = 4'b0001;
        tick(10);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0010) begin
            errors++;
            $display("FAIL mid_pre: got upd=%b mask=%b expected 1 0010", if1.update, if1.sw_changed);
        end
        if1.sw_async = 4'b0011;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        vectors++;
        if ({if1.resolution, if1.update, if1.sw_changed, if1.pwrup_done} !== 10'b0 ||
            if0.update !== 1'b0 || if0.pwrup_done !== 1'b0 || if0.resolution !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got m1=%b m0_upd=%b m0_done=%b m0_res=%b expected all 0",
                     {if1.resolution, if1.update, if1.sw_changed, if1.pwrup_done},
                     if0.update, if0.pwrup_done, if0.resolution);
        end
        rst_n = 1'b1;
        tick(9);
        vectors++;
        if (if1.update !== 1'b0 || if1.resolution !== 4'b0000) begin
            errors++;
            $display("FAIL mid_edge9: got upd=%b res=%b expected 0 0000", if1.update, if1.resolution);
        end
        tick(1);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0011 || if1.resolution !== 4'b0011) begin
            errors++;
            $display("FAIL mid_resettle: got upd=%b mask=%b res=%b expected 1 0011 0011",
                     if1.update, if1.sw_changed, if1.resolution);
        end
        tick(3);
        vectors++;
        if (if1.update !== 1'b1 || if1.sw_changed !== 4'b0011) begin
            errors++;
            $display("FAIL mid_single: got upd=%b mask=%b expected 1 0011", if1.update, if1.sw_changed);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_pwrup();
        test_settle();
        test_bounce();
        test_hold_accum();
        test_ack_collision();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
